// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read master and read-sniffer side.
package sram_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TIMER_W = 4;

  // Default phase lengths in 5 ns cycles (200 MHz)
  localparam int unsigned T_SETUP_DEF = 1;
  localparam int unsigned T_ACC_DEF   = 14;
  localparam int unsigned T_REC_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } sram_state_e;

  // Transfer in flight: current address and reads remaining after this one
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } sram_req_t;

  // Timer reload value for a phase lasting 'cycles' clock cycles
  function automatic logic [TIMER_W-1:0] phase_load(input int unsigned cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 4-bit phase down-counter; done is high once the loaded phase has elapsed.
module phase_timer
  import sram_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               done_q, done_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
    done_d = (count_d == '0);
  end

  // Counter and done flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/sram_read_master.sv
// Asynchronous SRAM burst read master with programmable setup/access/recovery.
module sram_read_master
  import sram_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_ACC   = T_ACC_DEF,
  parameter int unsigned T_REC   = T_REC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sram_e_n,
  output logic              sram_o_n,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq
);

  sram_state_e       state_q, state_d;
  sram_req_t         xfer_q, xfer_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              strobe_n_q, strobe_n_d;
  logic              busy_q, busy_d;
  logic              req_ready_q, req_ready_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_done;

  phase_timer u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .done    (tmr_done)
  );

  // Next-state, phase timer reload and registered output values
  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = ST_SETUP;
          xfer_d.addr = req_addr;
          xfer_d.len  = req_len;
          tmr_load    = 1'b1;
          tmr_value   = phase_load(T_SETUP);
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d   = ST_ACCESS;
          tmr_load  = 1'b1;
          tmr_value = phase_load(T_ACC);
        end
      end
      ST_ACCESS: begin
        if (tmr_done) begin
          state_d     = ST_RECOVER;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sram_dq;
          tmr_load    = 1'b1;
          tmr_value   = phase_load(T_REC);
        end
      end
      ST_RECOVER: begin
        if (tmr_done) begin
          if (xfer_q.len == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_SETUP;
            xfer_d.addr = xfer_q.addr + ADDR_W'(1);
            xfer_d.len  = xfer_q.len - LEN_W'(1);
            tmr_load    = 1'b1;
            tmr_value   = phase_load(T_SETUP);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes, busy and ready follow the state being entered
    strobe_n_d  = (state_d != ST_ACCESS);
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops the strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      xfer_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      strobe_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      xfer_q      <= xfer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      strobe_n_q  <= strobe_n_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  // One strobe register feeds both enables so they can never differ
  assign sram_e_n  = strobe_n_q;
  assign sram_o_n  = strobe_n_q;
  assign sram_addr = xfer_q.addr;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_sram_read_master.sv
// Directed bench for sram_read_master with an SRAM model and protocol monitor.
module tb_sram_read_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        sram_e_n;
  logic        sram_o_n;
  logic [14:0] sram_addr;
  logic [7:0]  sram_dq;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  sram_read_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .sram_e_n  (sram_e_n),
    .sram_o_n  (sram_o_n),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM contents: 0x1234 holds 0xA5, elsewhere lo ^ hi ^ 0x5A
  function automatic logic [7:0] mem(input logic [14:0] a);
    if (a == 15'h1234) return 8'hA5;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  // Bus only carries data while the SRAM is enabled and output-enabled
  always_comb sram_dq = (!sram_e_n && !sram_o_n) ? mem(sram_addr) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Protocol monitor, sampled on the falling edge
  int          rsp_cyc[$];
  logic [7:0]  rsp_dat[$];
  logic [14:0] rsp_adr[$];
  int          low_len[$];
  int          low_run = 0;
  int          high_run = 0;
  bit          seen_low = 1'b0;
  logic [14:0] prev_addr = '0;
  int          v_addr = 0, v_strobe = 0, v_gap = 0, v_ready = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      low_run  = 0;
      high_run = 0;
      seen_low = 1'b0;
    end else begin
      if (sram_e_n != sram_o_n) v_strobe++;
      if (busy && req_ready) v_ready++;
      if (!sram_e_n) begin
        if (sram_addr != prev_addr) v_addr++;
        if (low_run == 0 && seen_low && high_run < 2) v_gap++;
        low_run++;
        high_run = 0;
      end else begin
        if (low_run > 0) begin
          low_len.push_back(low_run);
          seen_low = 1'b1;
        end
        low_run = 0;
        high_run++;
      end
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(rsp_data);
        rsp_adr.push_back(sram_addr);
      end
    end
    prev_addr = sram_addr;
  end

  task automatic clear_log();
    rsp_cyc.delete();
    rsp_dat.delete();
    rsp_adr.delete();
    low_len.delete();
  endtask

  // Present a request for one edge and record the accept cycle
  task automatic send(input logic [14:0] a, input logic [7:0] l);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input int idx, input int lat,
                           input logic [14:0] a, input logic [7:0] d);
    if (rsp_cyc.size() > idx) begin
      check({tag, "_lat"},  32'(rsp_cyc[idx] - acc_cyc), 32'(lat));
      check({tag, "_addr"}, 32'(rsp_adr[idx]), 32'(a));
      check({tag, "_data"}, 32'(rsp_dat[idx]), 32'(d));
    end else begin
      check({tag, "_missing"}, 32'(rsp_cyc.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_e_n",       32'(sram_e_n),  32'd1);
    check("rst_o_n",       32'(sram_o_n),  32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_addr",      32'(sram_addr), 32'd0);
    check("rst_ready",     32'(req_ready), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read: 14 low cycles, response 15 cycles after accept
    clear_log();
    send(15'h1234, 8'd0);
    wait_idle();
    check("single_cnt", 32'(rsp_cyc.size()), 32'd1);
    check_rsp("single", 0, 15, 15'h1234, 8'hA5);
    if (low_len.size() > 0) check("single_low_len", 32'(low_len[0]), 32'd14);
    else                    check("single_low_cnt", 32'(low_len.size()), 32'd1);
    check("single_hold", 32'(rsp_data), 32'hA5);

    // Burst of 4 with a stray request held high while busy
    clear_log();
    send(15'h0010, 8'd3);
    req_valid = 1'b1;
    req_addr  = 15'h5555;
    req_len   = 8'd0;
    repeat (40) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    check("burst_cnt", 32'(rsp_cyc.size()), 32'd4);
    check_rsp("burst0", 0, 15, 15'h0010, 8'h4A);
    check_rsp("burst1", 1, 32, 15'h0011, 8'h4B);
    check_rsp("burst2", 2, 49, 15'h0012, 8'h48);
    check_rsp("burst3", 3, 66, 15'h0013, 8'h49);
    check("burst_low_cnt", 32'(low_len.size()), 32'd4);

    // Address wrap across 0x7FFF
    clear_log();
    send(15'h7FFE, 8'd2);
    wait_idle();
    check("wrap_cnt", 32'(rsp_cyc.size()), 32'd3);
    check_rsp("wrap0", 0, 15, 15'h7FFE, 8'hDB);
    check_rsp("wrap1", 1, 32, 15'h7FFF, 8'hDA);
    check_rsp("wrap2", 2, 49, 15'h0000, 8'h5A);

    // Reset during the fifth access cycle
    clear_log();
    send(15'h1234, 8'd0);
    begin
      int n = 0;
      while (sram_e_n && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("midrst_strobe_timeout", 32'(n < 50), 32'd1);
    end
    repeat (4) @(negedge clk);
    check("midrst_in_access", 32'(sram_e_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_e_n",  32'(sram_e_n),  32'd1);
    check("midrst_o_n",  32'(sram_o_n),  32'd1);
    check("midrst_busy", 32'(busy),      32'd0);
    check("midrst_rv",   32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_cyc.size()), 32'd0);
    clear_log();

    // First edge after reset release accepts the request
    reset_n   = 1'b1;
    req_valid = 1'b1;
    req_addr  = 15'h1234;
    req_len   = 8'd0;
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    check("postrst_accept", 32'(busy), 32'd1);
    wait_idle();
    check("postrst_cnt", 32'(rsp_cyc.size()), 32'd1);
    check_rsp("postrst", 0, 15, 15'h1234, 8'hA5);

    // Protocol monitor totals
    check("proto_addr_change", 32'(v_addr),   32'd0);
    check("proto_strobe_eq",   32'(v_strobe), 32'd0);
    check("proto_rec_gap",     32'(v_gap),    32'd0);
    check("proto_ready_busy",  32'(v_ready),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sram_read_master.md
SRAM_READ_MASTER -- requirements
Module: sram_read_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 1: cycles address is stable before sram_e_n/sram_o_n fall; legal range 1..15.
REQ-002 SHALL have parameter T_ACC, default 14: cycles sram_e_n/sram_o_n are held low per read, i.e. 70 ns at 200 MHz; legal range 1..15.
REQ-003 SHALL have parameter T_REC, default 2: cycles both strobes stay high between reads; legal range 1..15.
REQ-004 clk  input  1: single clock, 200 MHz PLL output; all logic runs on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 req_valid  input  1: read request present.
REQ-007 req_ready  output  1: block can accept a request.
REQ-008 req_addr  input  15: start address of the read.
REQ-009 req_len  input  8: number of reads minus 1 (0 means 1 read, 255 means 256 reads).
REQ-010 rsp_valid  output  1: one-cycle pulse, rsp_data is valid.
REQ-011 rsp_data  output  8: captured SRAM byte.
REQ-012 busy  output  1: high in any state other than IDLE.
REQ-013 sram_e_n  output  1: active-low chip enable to SRAM.
REQ-014 sram_o_n  output  1: active-low output enable to SRAM.
REQ-015 sram_addr  output  15: address bus to SRAM.
REQ-016 sram_dq  input  8: SRAM data bus, read-only at this block.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RECOVER, all registered.
REQ-018 req_ready SHALL be high only in IDLE; a transfer occurs when req_valid and req_ready are both high on a rising edge.
REQ-019 On accept, the block SHALL latch req_addr into sram_addr and req_len into a remaining counter, then enter SETUP on the next cycle.
REQ-020 SETUP SHALL last exactly T_SETUP cycles with both strobes high and sram_addr stable, then go to ACCESS.
REQ-021 ACCESS SHALL last exactly T_ACC cycles with sram_e_n=0 and sram_o_n=0.
REQ-022 The rising edge that ends ACCESS SHALL register sram_dq into rsp_data, pulse rsp_valid for 1 cycle, drive both strobes high, and enter RECOVER.
REQ-023 RECOVER SHALL last exactly T_REC cycles with both strobes high, then:
- remaining=0: go to IDLE.
- otherwise: decrement remaining, increment sram_addr, go to SETUP.
REQ-024 sram_addr SHALL increment modulo 2^15, so 0x7FFF wraps to 0x0000 with no error flag.
REQ-025 sram_addr SHALL change only in IDLE-accept or at RECOVER exit, never while either strobe is low.
REQ-026 sram_e_n and sram_o_n SHALL be driven directly from registers (glitch-free) and SHALL always be equal.
REQ-027 Per-phase timing SHALL use one 4-bit down-counter reloaded at each phase entry.
REQ-028 Single-read latency from accept to the rsp_valid edge SHALL be T_SETUP+T_ACC cycles; spacing between rsp_valid pulses in a burst SHALL be T_REC+T_SETUP+T_ACC cycles.
REQ-029 req_valid SHALL be ignored outside IDLE; there is no request queueing.
REQ-030 rsp_data SHALL hold its last value until the next capture.

Reset
REQ-031 reset_n low SHALL asynchronously force:
- state: IDLE
- strobes: sram_e_n=1, sram_o_n=1
- outputs: rsp_valid=0, rsp_data=0, busy=0, sram_addr=0
- counters: 0
- req_ready=1 after release
REQ-032 Reset asserted mid-ACCESS SHALL deassert both strobes in the same cycle, with no rsp_valid pulse.
REQ-033 After reset_n rises, the first request SHALL be accepted on the first clock edge.

Structure
REQ-034 State encoding and the T_SETUP/T_ACC/T_REC defaults SHALL live in shared package sram_pkg, reused by the read-sniffer side.
REQ-035 The phase counter SHALL be a sub-module phase_timer (load, value, done), compatible in width with the 5 ns timer.

Verification
REQ-036 Single read: addr=0x1234, len=0, SRAM model returns 0xA5 -> strobes low for exactly 14 cycles; rsp_data=0xA5 with rsp_valid at cycle 15 after accept.
REQ-037 Burst: addr=0x0010, len=3 -> 4 rsp_valid pulses 17 cycles apart; addresses 0x10..0x13; data matches the model.
REQ-038 Wrap: addr=0x7FFE, len=2 -> sram_addr sequence 0x7FFE, 0x7FFF, 0x0000.
REQ-039 Mid-op reset: reset_n low at ACCESS cycle 5 -> strobes high in the same cycle, no rsp_valid; a later request completes normally.
REQ-040 Protocol checker across all runs:
- no sram_addr change while strobes are low
- req_valid held high while busy is never accepted
- strobe-high gap between reads is at least T_REC cycles
